// File: rtl/seg7_scan_decoder_pkg.sv
// rtl/seg7_scan_decoder_pkg.sv - shared types, constants and glyph table for the scan decoder
package seg7_scan_decoder_pkg;

    localparam int          NUM_DIGITS  = 8;
    localparam int          SAMPLE_W    = 16;
    localparam logic [15:0] SAMPLE_IDLE = 16'hFFFF;
    localparam logic [6:0]  SEG_BLANK   = 7'h00;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } glyph_t;

    // Lit-segment pattern {a,b,c,d,e,f,g} (1 = lit) for each hex digit.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] n);
        logic [6:0] pat;
        case (n)
            4'h0:    pat = 7'h7E;
            4'h1:    pat = 7'h30;
            4'h2:    pat = 7'h6D;
            4'h3:    pat = 7'h79;
            4'h4:    pat = 7'h33;
            4'h5:    pat = 7'h5B;
            4'h6:    pat = 7'h5F;
            4'h7:    pat = 7'h70;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h7B;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h1F;
            4'hC:    pat = 7'h4E;
            4'hD:    pat = 7'h3D;
            4'hE:    pat = 7'h4F;
            default: pat = 7'h47;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// rtl/seg7_scan_decoder_if.sv - scanned 7-segment pin bundle (all lines active-low)
interface seg7_scan_if;
    logic [7:0] AN;
    logic       CA;
    logic       CB;
    logic       CC;
    logic       CD;
    logic       CE;
    logic       CF;
    logic       CG;
    logic       DP;

    modport master (output AN, CA, CB, CC, CD, CE, CF, CG, DP);
    modport slave  (input  AN, CA, CB, CC, CD, CE, CF, CG, DP);
endinterface

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - combinational lit-segment pattern to {valid, nibble}
module seg7_glyph_decode
    import seg7_scan_decoder_pkg::*;
(
    input  logic [6:0] seg_i,
    output glyph_t     glyph_o
);

    always_comb begin
        glyph_o = '0;
        for (int n = 0; n < 16; n++) begin
            if (seg_i == seg7_glyph(4'(n))) begin
                glyph_o.valid  = 1'b1;
                glyph_o.nibble = 4'(n);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - rebuilds 8-digit display content from scanned anode/segment pins
module seg7_scan_decoder
    import seg7_scan_decoder_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  scan,
    output logic [31:0] HEX,
    output logic [7:0]  HEX_VALID,
    output logic [7:0]  DP_LAT,
    output logic        FRAME_DONE,
    output logic        MULTI_ERR
);

    localparam int            CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SAMPLE_W-1:0] sync_q [SYNC_STAGES];
    logic [SAMPLE_W-1:0] pins_raw;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                captured_q, captured_d;
    logic [7:0]          seen_q, seen_d;
    logic [31:0]         hex_q, hex_d;
    logic [7:0]          valid_q, valid_d;
    logic [7:0]          dp_q, dp_d;
    logic                frame_q, frame_d;
    logic                err_q, err_d;

    logic [7:0] an;
    logic       changed, fire, one_hot, multi_hot;
    logic [2:0] digit_idx;
    logic [7:0] seen_next;
    glyph_t     glyph;

    assign pins_raw = {scan.AN, scan.CA, scan.CB, scan.CC, scan.CD,
                       scan.CE, scan.CF, scan.CG, scan.DP};
    assign sample   = sync_q[SYNC_STAGES-1];
    assign an       = ~sample[15:8];

    seg7_glyph_decode u_glyph (
        .seg_i   (~sample[7:1]),
        .glyph_o (glyph)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= SAMPLE_IDLE;
        end else begin
            sync_q[0] <= pins_raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    always_comb begin
        one_hot   = (an != 8'h00) && ((an & (an - 8'd1)) == 8'h00);
        multi_hot = (an != 8'h00) && !one_hot;
        digit_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an[i]) digit_idx = 3'(i);
        end
    end

    // A dwell fires exactly once: when the run length first hits the threshold.
    always_comb begin
        changed    = (sample != prev_q);
        cnt_d      = cnt_q;
        captured_d = captured_q;
        if (changed) begin
            cnt_d      = CNT_W'(1);
            captured_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        fire = (cnt_d == CNT_MAX) && !captured_d;
        if (fire) captured_d = 1'b1;
    end

    always_comb begin
        hex_d     = hex_q;
        valid_d   = valid_q;
        dp_d      = dp_q;
        frame_d   = 1'b0;
        err_d     = fire && multi_hot;
        seen_next = seen_q;
        if (fire && one_hot) begin
            hex_d[4*digit_idx +: 4] = glyph.nibble;
            valid_d[digit_idx]      = glyph.valid;
            dp_d[digit_idx]         = ~sample[0];
            seen_next               = seen_q | an;
        end
        // The completing digit belongs to the old frame, so the new mask starts empty.
        if (seen_next == 8'hFF) begin
            frame_d = 1'b1;
            seen_d  = 8'h00;
        end else begin
            seen_d  = seen_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q     <= SAMPLE_IDLE;
            cnt_q      <= '0;
            captured_q <= 1'b0;
            seen_q     <= '0;
            hex_q      <= '0;
            valid_q    <= '0;
            dp_q       <= '0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_q     <= sample;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            seen_q     <= seen_d;
            hex_q      <= hex_d;
            valid_q    <= valid_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
        end
    end

    assign HEX        = hex_q;
    assign HEX_VALID  = valid_q;
    assign DP_LAT     = dp_q;
    assign FRAME_DONE = frame_q;
    assign MULTI_ERR  = err_q;

endmodule
